// File: rtl/cpu_check_pkg.sv
// Shared types and defaults for the CPU trace checker.
// Entry layout packs {addr, result} into one 64-bit word.
package cpu_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_HALT  = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] result;
  } entry_t;

endpackage

// File: rtl/cpu_trace_checker_ram.sv
// Expected-trace register file.
// One synchronous write port, one asynchronous read port.
module trace_ram
  import cpu_check_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_checker.sv
// Compares the CPU addr/result stream against a preloaded trace,
// counting mismatches and flagging a stuck PC.
module cpu_trace_checker
  import cpu_check_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int AW          = 4,
  parameter int HALT_CYCLES = DEF_HALT
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [31:0]   addr,
  input  logic [31:0]   result,
  input  logic          exp_we,
  input  logic [AW-1:0] exp_waddr,
  input  logic [31:0]   exp_wdata_addr,
  input  logic [31:0]   exp_wdata_result,
  input  logic [AW:0]   exp_len,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          halted,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_idx
);

  localparam int SW = 8;

  state_t        state, state_d;
  logic [AW-1:0] idx;
  logic [AW:0]   len;
  logic [SW-1:0] stall_cnt;
  logic [31:0]   prev_addr;
  logic          fresh;
  entry_t        rd;

  logic          mis, rpt, hit, last;
  logic [SW-1:0] cnt_nx;
  logic [AW:0]   err_nx;

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (Clock),
    .we    (exp_we && state != RUN),
    .waddr (exp_waddr),
    .wdata ({exp_wdata_addr, exp_wdata_result}),
    .raddr (idx),
    .rdata (rd)
  );

  always_comb begin
    mis    = (addr != rd.addr) || (result != rd.result);
    err_nx = err_count + (AW+1)'(mis);
    rpt    = !fresh && (addr == prev_addr);
    cnt_nx = rpt ? stall_cnt + SW'(1) : '0;
    hit    = rpt && (cnt_nx == SW'(HALT_CYCLES - 1));
    last   = ({1'b0, idx} == len - (AW+1)'(1));
    state_d = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = (exp_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last || hit) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      halted        <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      idx           <= '0;
      len           <= '0;
      stall_cnt     <= '0;
      prev_addr     <= '0;
      fresh         <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == RUN);
      done  <= (state_d == DONE);
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            len           <= exp_len;
            idx           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            halted        <= 1'b0;
            stall_cnt     <= '0;
            fresh         <= 1'b1;
            pass          <= (exp_len == '0);
          end
        end
        RUN: begin
          err_count <= err_nx;
          if (mis && err_count == '0) begin
            first_err_idx <= idx;
          end
          idx       <= idx + AW'(1);
          prev_addr <= addr;
          fresh     <= 1'b0;
          stall_cnt <= cnt_nx;
          if (last || hit) begin
            pass   <= (err_nx == '0) && !hit;
            halted <= hit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed self-checking bench for cpu_trace_checker.
module tb_cpu_trace_checker;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] result = '0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_waddr = '0;
  logic [31:0] exp_wdata_addr = '0;
  logic [31:0] exp_wdata_result = '0;
  logic [4:0]  exp_len = '0;
  logic        busy, done, pass, halted;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;

  int passed = 0;
  int total = 0;

  logic [31:0] va [8];
  logic [31:0] vr [8];

  always #5 Clock = ~Clock;

  cpu_trace_checker dut (
    .Clock            (Clock),
    .Reset_n          (Reset_n),
    .start            (start),
    .addr             (addr),
    .result           (result),
    .exp_we           (exp_we),
    .exp_waddr        (exp_waddr),
    .exp_wdata_addr   (exp_wdata_addr),
    .exp_wdata_result (exp_wdata_result),
    .exp_len          (exp_len),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .halted           (halted),
    .err_count        (err_count),
    .first_err_idx    (first_err_idx)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input int i, input logic [31:0] a,
                    input logic [31:0] r);
    exp_we = 1'b1;
    exp_waddr = 4'(i);
    exp_wdata_addr = a;
    exp_wdata_result = r;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic go(input int n);
    start = 1'b1;
    exp_len = 5'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] r);
    addr = a;
    result = r;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      va[i] = 32'(4 * i);
      vr[i] = 32'(5 * (i + 1));
    end

    // reset values
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_first", 64'(first_err_idx), 64'd0);
    chk("rst_state", 64'(dut.state), 64'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < 8; i++) wr(i, va[i], vr[i]);

    // clean run
    go(4);
    chk("clean_busy0", 64'(busy), 64'd1);
    chk("clean_done0", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vr[i]);
      chk("clean_busy", 64'(busy), 64'd1);
    end
    drive(va[3], vr[3]);
    chk("clean_busy_end", 64'(busy), 64'd0);
    chk("clean_done", 64'(done), 64'd1);
    chk("clean_pass", 64'(pass), 64'd1);
    chk("clean_err", 64'(err_count), 64'd0);
    chk("clean_halted", 64'(halted), 64'd0);

    // asynchronous reset mid-cycle
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_done", 64'(done), 64'd0);
    chk("async_pass", 64'(pass), 64'd0);
    chk("async_state", 64'(dut.state), 64'd0);
    Reset_n = 1'b1;

    // mismatches
    wr(2, 32'h8, 32'hE);
    wr(3, 32'h10, 32'h14);
    go(4);
    for (int i = 0; i < 4; i++) drive(va[i], vr[i]);
    chk("mis_done", 64'(done), 64'd1);
    chk("mis_pass", 64'(pass), 64'd0);
    chk("mis_err", 64'(err_count), 64'd2);
    chk("mis_first", 64'(first_err_idx), 64'd2);
    chk("mis_halted", 64'(halted), 64'd0);

    // stall
    wr(2, va[2], vr[2]);
    wr(3, va[3], vr[3]);
    go(8);
    drive(32'h0, 32'h5);
    drive(32'h4, 32'hA);
    drive(32'h8, 32'hF);
    drive(32'h8, 32'h14);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_done_early", 64'(done), 64'd0);
    drive(32'h8, 32'h19);
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_busy_end", 64'(busy), 64'd0);
    chk("stall_halted", 64'(halted), 64'd1);
    chk("stall_pass", 64'(pass), 64'd0);
    chk("stall_err", 64'(err_count), 64'd2);
    chk("stall_first", 64'(first_err_idx), 64'd3);

    // zero length
    go(0);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_pass", 64'(pass), 64'd1);
    chk("zero_halted", 64'(halted), 64'd0);
    chk("zero_err", 64'(err_count), 64'd0);

    // start and exp_we ignored during RUN
    go(4);
    drive(va[0], vr[0]);
    start = 1'b1;
    exp_len = 5'd2;
    exp_we = 1'b1;
    exp_waddr = 4'd0;
    exp_wdata_addr = 32'hDEAD;
    exp_wdata_result = 32'hBEEF;
    drive(va[1], vr[1]);
    start = 1'b0;
    exp_we = 1'b0;
    drive(va[2], vr[2]);
    chk("ign_done_early", 64'(done), 64'd0);
    chk("ign_busy", 64'(busy), 64'd1);
    drive(va[3], vr[3]);
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_pass", 64'(pass), 64'd1);
    chk("ign_err", 64'(err_count), 64'd0);
    chk("ign_table", 64'(dut.u_ram.mem[0]), {32'h0, 32'h5});

    // reset mid-run, then rerun
    go(4);
    drive(va[0], vr[0]);
    addr = va[1];
    result = vr[1];
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_state", 64'(dut.state), 64'd0);
    Reset_n = 1'b1;
    tick();
    chk("mid_done_after", 64'(done), 64'd0);
    go(4);
    for (int i = 0; i < 4; i++) drive(va[i], vr[i]);
    chk("rerun_done", 64'(done), 64'd1);
    chk("rerun_pass", 64'(pass), 64'd1);
    chk("rerun_err", 64'(err_count), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
